// File: rtl/seq_add_pkg.sv
// seq_add_pkg: shared types and default constants for the sequential adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   WIDTH_DEF : default operand/sum width in bits
//   CHUNK_DEF : default number of bits added per RUN cycle
package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int CHUNK_DEF = 1;

endpackage

// File: rtl/seq_add_chunk_add.sv
// chunk_add: CHUNK-bit ripple-carry adder built from 1-bit full-adder cells.
//   x, y : CHUNK-bit addends
//   ci   : carry-in
//   s    : CHUNK-bit sum
//   co   : carry-out of the most significant cell
module chunk_add #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    // c_s[i] is the carry into cell i; c_s[CHUNK] leaves the chunk.
    logic [CHUNK:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ c_s[i];
        assign c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
    end

    assign co = c_s[CHUNK];

endmodule

// File: rtl/seq_add.sv
// seq_add: sequential adder, CHUNK bits per cycle over WIDTH/CHUNK RUN cycles.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : begin an addition (accepted when ready is high)
//   a, b  : WIDTH-bit operands, sampled on acceptance
//   cin   : carry-in, sampled on acceptance
//   ready : high while IDLE
//   sum   : registered result, updated only on entry to DONE
//   cout  : registered carry-out, updated with sum
//   done  : one-cycle pulse while in DONE
//   ovf   : registered signed overflow (only when SEQ_ADD_OVF_EN is defined)
// Optional feature macro: SEQ_ADD_OVF_EN
module seq_add
    import seq_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    // One extra bit so the counter can never wrap within an operation.
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_add: WIDTH must be an integer multiple of CHUNK");
    end

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] psum_r;
    logic [WIDTH-1:0] psum_next_s;
    logic [CHUNK-1:0] add_s;
    logic             add_co_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             done_r;

    assign accept_s = start && (state_r == IDLE);
    assign last_s   = (state_r == RUN) && (cnt_r == LAST);
    assign ready    = (state_r == IDLE);
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign done     = done_r;

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .x  (a_r[CHUNK-1:0]),
        .y  (b_r[CHUNK-1:0]),
        .ci (carry_r),
        .s  (add_s),
        .co (add_co_s)
    );

    // Partial sum fills from the MSB side so after N cycles it is aligned.
    always_comb begin
        psum_next_s                    = psum_r >> CHUNK;
        psum_next_s[WIDTH-1 -: CHUNK]  = add_s;
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Controller next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Operand shift registers, carry and chunk counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            cnt_r   <= {CW{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
        end else if (state_r == RUN) begin
            a_r     <= a_r >> CHUNK;
            b_r     <= b_r >> CHUNK;
            carry_r <= add_co_s;
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            psum_r  <= psum_next_s;
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
            psum_r  <= psum_r;
        end
    end

    // Result registers, loaded only on the final RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            done_r <= 1'b0;
        end else if (last_s) begin
            sum_r  <= psum_next_s;
            cout_r <= add_co_s;
            done_r <= 1'b1;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
            done_r <= 1'b0;
        end
    end

`ifdef SEQ_ADD_OVF_EN
    // The operand registers shift away their MSBs, so keep copies for ovf.
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    assign ovf = ovf_r;

    // Operand sign bits captured at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
        end else if (accept_s) begin
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
        end else begin
            a_msb_r <= a_msb_r;
            b_msb_r <= b_msb_r;
        end
    end

    // Signed overflow, registered alongside sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (last_s) begin
            ovf_r <= (a_msb_r == b_msb_r) && (psum_next_s[WIDTH-1] != a_msb_r);
        end else begin
            ovf_r <= ovf_r;
        end
    end
`endif

endmodule

// File: tb/tb_seq_add.sv
// tb_seq_add: directed bench for seq_add with three instances sharing the
// operand inputs: CHUNK=1 (N=8), CHUNK=2 (N=4), CHUNK=4 (N=2), all WIDTH=8.
// Latency is counted as the number of rising edges from the accepting edge
// up to and including the edge at which done is captured high.
module tb_seq_add;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    logic       rdy1, rdy2, rdy4;
    logic [7:0] sum1, sum2, sum4;
    logic       cout1, cout2, cout4;
    logic       done1, done2, done4;
`ifdef SEQ_ADD_OVF_EN
    logic       ovf1, ovf2, ovf4;
`endif

    always #5 clk = ~clk;

    seq_add #(.WIDTH(8), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .ready(rdy1), .sum(sum1), .cout(cout1), .done(done1)
`ifdef SEQ_ADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

    seq_add #(.WIDTH(8), .CHUNK(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .ready(rdy2), .sum(sum2), .cout(cout2), .done(done2)
`ifdef SEQ_ADD_OVF_EN
        , .ovf(ovf2)
`endif
    );

    seq_add #(.WIDTH(8), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .ready(rdy4), .sum(sum4), .cout(cout4), .done(done4)
`ifdef SEQ_ADD_OVF_EN
        , .ovf(ovf4)
`endif
    );

    // Index 0: CHUNK=1, index 1: CHUNK=2, index 2: CHUNK=4.
    logic [7:0] sum_v  [3];
    logic       cout_v [3];
    logic       done_v [3];
    logic       rdy_v  [3];
    assign sum_v[0]  = sum1;  assign sum_v[1]  = sum2;  assign sum_v[2]  = sum4;
    assign cout_v[0] = cout1; assign cout_v[1] = cout2; assign cout_v[2] = cout4;
    assign done_v[0] = done1; assign done_v[1] = done2; assign done_v[2] = done4;
    assign rdy_v[0]  = rdy1;  assign rdy_v[1]  = rdy2;  assign rdy_v[2]  = rdy4;
`ifdef SEQ_ADD_OVF_EN
    logic ovf_v [3];
    assign ovf_v[0] = ovf1; assign ovf_v[1] = ovf2; assign ovf_v[2] = ovf4;
`endif

    int n_of [3] = '{8, 4, 2};

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    // One operation on all three instances, with garbage on the inputs after
    // acceptance and an ignored start pulse during RUN.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic [7:0] es, input logic ec, input logic eov);
        int         lat  [3];
        int         cnt  [3];
        bit         held [3];
        logic [7:0] prev [3];
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0; cnt[i] = 0; held[i] = 1'b1; prev[i] = sum_v[i];
            chk($sformatf("ready_before[%0d]", i), 32'(rdy_v[i]), 32'd1);
        end
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            start = (k == 1) ? 1'b1 : 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) begin
                    cnt[i]++;
                    if (lat[i] == 0) lat[i] = k + 1;
                end else if (cnt[i] == 0 && sum_v[i] !== prev[i]) begin
                    held[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("latency[%0d]", i), 32'(lat[i]), 32'(n_of[i] + 1));
            chk($sformatf("done_count[%0d]", i), 32'(cnt[i]), 32'd1);
            chk($sformatf("sum[%0d] %h+%h+%h", i, ia, ib, ic), 32'(sum_v[i]), 32'(es));
            chk($sformatf("cout[%0d] %h+%h+%h", i, ia, ib, ic), 32'(cout_v[i]), 32'(ec));
            chk($sformatf("sum_held[%0d]", i), 32'(held[i]), 32'd1);
`ifdef SEQ_ADD_OVF_EN
            chk($sformatf("ovf[%0d] %h+%h", i, ia, ib), 32'(ovf_v[i]), 32'(eov));
`else
            if (eov === 1'bx) $display("note: unknown ovf expectation");
`endif
        end
    endtask

    vec_t vecs [8];
    logic [7:0] va [30];
    logic [7:0] vb [30];

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_sum[%0d]", i),   32'(sum_v[i]),  32'd0);
            chk($sformatf("rst_cout[%0d]", i),  32'(cout_v[i]), 32'd0);
            chk($sformatf("rst_done[%0d]", i),  32'(done_v[i]), 32'd0);
            chk($sformatf("rst_ready[%0d]", i), 32'(rdy_v[i]),  32'd1);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Table of hand-computed vectors.
        for (int v = 0; v < 8; v++) begin
            do_op(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].s, vecs[v].co, vecs[v].ov);
        end

        // Random operands against the arithmetic definition.
        for (int r = 0; r < 16; r++) begin
            logic [7:0] ra, rb, es;
            logic       rc, ec, eov;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            {ec, es} = 9'(ra) + 9'(rb) + 9'(rc);
            eov = (ra[7] == rb[7]) && (es[7] != ra[7]);
            do_op(ra, rb, rc, es, ec, eov);
        end

        // Reset during the third RUN cycle of the CHUNK=1 instance.
        @(negedge clk);
        a = 8'h55; b = 8'h66; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_sum",   32'(sum1),  32'd0);
        chk("abort_cout",  32'(cout1), 32'd0);
        chk("abort_ready", 32'(rdy1),  32'd1);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk);
                #1;
                if (done1 || done2) seen++;
            end
            chk("abort_no_done", 32'(seen), 32'd0);
        end
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // start held high with operands changing every cycle (CHUNK=1):
        // acceptance edge, 8 RUN cycles and the DONE cycle precede the next
        // IDLE, so acceptances fall on edges 0, 10 and 20.
        for (int e = 0; e < 30; e++) begin
            va[e] = 8'($urandom);
            vb[e] = 8'($urandom);
        end
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            a = va[e]; b = vb[e]; cin = 1'b0; start = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("held_done@%0d", e), 32'(done1), 32'((e % 10) == 8));
            if ((e % 10) == 8) begin
                logic [8:0] ex;
                ex = 9'(va[e - 8]) + 9'(vb[e - 8]);
                chk($sformatf("held_sum@%0d", e),  32'(sum1),  32'(ex[7:0]));
                chk($sformatf("held_cout@%0d", e), 32'(cout1), 32'(ex[8]));
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
